jzjpcc_execute_skid_reg: RTL and testbench

Parametrised decode→execute pipeline register with a two-entry skid buffer, valid/ready handshake and flush. Sits between the decode stage and the execute stage and carries the full execute control/data bundle, including the memory enables. Breaks the combinational ready path from execute back into decode, and exports hazard information about held instructions for decode's stall logic.

---
 rtl/jzjpcc_pkg.sv | 40 ++++
 rtl/jzjpcc_sat_counter.sv | 25 ++
 rtl/jzjpcc_execute_skid_reg.sv | 115 +++++++++++
 tb/tb_jzjpcc_execute_skid_reg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jzjpcc_pkg.sv
// rtl/jzjpcc_pkg.sv - shared types and field positions for the decode->execute skid register
//
// Purpose: execute bundle layout, bundle width helper and skid buffer state encoding.
// Ports: none (package).
package jzjpcc_pkg;

  localparam int PC_MAX_B_DEF = 15;

  // Bundle width is the sum of the field widths; currentPC spans [pc_max_b:2].
  function automatic int bundle_w(input int pc_max_b);
    return 109 + pc_max_b;
  endfunction

  typedef struct packed {
    logic [31:0]             immediate;
    logic [31:0]             rs1;
    logic [31:0]             rs2;
    logic [PC_MAX_B_DEF:2]   currentPC;
    logic [4:0]              rdAddr;
    logic [2:0]              aluOperation;
    logic                    aluMod;
    logic [1:0]              aluMuxMode;
    logic                    rdWriteEnable;
    logic                    memoryWriteEnable;
    logic                    memoryReadEnable;
  } execute_bundle_t;

  // The hazard-relevant fields sit below currentPC, so their positions do not
  // depend on the PC width and can be sliced from a flat bundle vector.
  localparam int MEM_RE_BIT  = 0;
  localparam int RD_WE_BIT   = 2;
  localparam int RD_ADDR_LSB = 9;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/jzjpcc_sat_counter.sv
// rtl/jzjpcc_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts cycles with inc=1, sticks at all-ones; clear wins over inc.
// Ports: clock, reset (async active-low), inc, clear, count[CNT_W-1:0].
module jzjpcc_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/jzjpcc_execute_skid_reg.sv
// rtl/jzjpcc_execute_skid_reg.sv - decode->execute pipeline register with two-entry skid buffer
//
// Purpose: registers the execute bundle, decouples execute's ready from decode,
//          supports flush and exports hazard info about held instructions.
// Ports: clock, reset (async active-low); inValid/inReady/inBundle from decode;
//        outValid/outReady/outBundle to execute; flush; hazardRdAddr0/1, hazardLoad;
//        bubbleCount (saturating), clearCount.
module jzjpcc_execute_skid_reg
  import jzjpcc_pkg::*;
#(
  parameter  int PC_MAX_B = 15,
  parameter  int CNT_W    = 16,
  localparam int BUNDLE_W = bundle_w(PC_MAX_B)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inValid,
  output logic                inReady,
  input  logic [BUNDLE_W-1:0] inBundle,
  output logic                outValid,
  input  logic                outReady,
  output logic [BUNDLE_W-1:0] outBundle,
  input  logic                flush,
  output logic [4:0]          hazardRdAddr0,
  output logic [4:0]          hazardRdAddr1,
  output logic                hazardLoad,
  output logic [CNT_W-1:0]    bubbleCount,
  input  logic                clearCount
);

  skid_state_e         state_q, state_d;
  logic [BUNDLE_W-1:0] head_q, skid_q;
  logic                load_head, head_from_skid, load_skid;
  logic                accept, consume;

  // Both handshake signals derive from the state register only, so no
  // combinational path runs from outReady to inReady.
  assign inReady  = (state_q != TWO);
  assign outValid = (state_q != EMPTY);
  assign accept   = inValid & inReady & ~flush;
  assign consume  = outValid & outReady;

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_head = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state_d        = ONE;
            load_head      = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_head) begin
        head_q <= head_from_skid ? skid_q : inBundle;
      end
      if (load_skid) begin
        skid_q <= inBundle;
      end
    end
  end

  assign outBundle = head_q;

  // Entry data is stale when its entry is invalid, so every hazard output is gated by state.
  assign hazardRdAddr0 = (outValid && head_q[RD_WE_BIT])
                         ? head_q[RD_ADDR_LSB +: 5] : 5'd0;
  assign hazardRdAddr1 = ((state_q == TWO) && skid_q[RD_WE_BIT])
                         ? skid_q[RD_ADDR_LSB +: 5] : 5'd0;
  assign hazardLoad    = outValid & head_q[MEM_RE_BIT];

  jzjpcc_sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (~outValid),
    .clear(clearCount),
    .count(bubbleCount)
  );

endmodule

// File: tb/tb_jzjpcc_execute_skid_reg.sv
// tb/tb_jzjpcc_execute_skid_reg.sv - self-checking bench for jzjpcc_execute_skid_reg
module tb_jzjpcc_execute_skid_reg;
  import jzjpcc_pkg::*;

  localparam int CNT_W = 4;
  localparam int BW    = bundle_w(PC_MAX_B_DEF);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [BW-1:0] inBundle = '0;
  logic          outValid;
  logic          outReady = 1'b0;
  logic [BW-1:0] outBundle;
  logic          flush = 1'b0;
  logic [4:0]    hazardRdAddr0, hazardRdAddr1;
  logic          hazardLoad;
  logic [CNT_W-1:0] bubbleCount;
  logic          clearCount = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model: a FIFO of at most two bundles plus a saturating counter.
  execute_bundle_t q[$];
  int              m_cnt = 0;

  jzjpcc_execute_skid_reg #(
    .PC_MAX_B(PC_MAX_B_DEF),
    .CNT_W   (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .inValid      (inValid),
    .inReady      (inReady),
    .inBundle     (inBundle),
    .outValid     (outValid),
    .outReady     (outReady),
    .outBundle    (outBundle),
    .flush        (flush),
    .hazardRdAddr0(hazardRdAddr0),
    .hazardRdAddr1(hazardRdAddr1),
    .hazardLoad   (hazardLoad),
    .bubbleCount  (bubbleCount),
    .clearCount   (clearCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic execute_bundle_t make_bundle(input logic [4:0] rd, input logic we,
                                                  input logic re);
    execute_bundle_t b;
    b.immediate         = $urandom;
    b.rs1               = $urandom;
    b.rs2               = $urandom;
    b.currentPC         = 14'($urandom);
    b.rdAddr            = rd;
    b.aluOperation      = 3'($urandom);
    b.aluMod            = 1'($urandom);
    b.aluMuxMode        = 2'($urandom);
    b.rdWriteEnable     = we;
    b.memoryWriteEnable = 1'($urandom);
    b.memoryReadEnable  = re;
    return b;
  endfunction

  // Advance one clock: update the model from the inputs present before the
  // edge, then sample DUT outputs 1 time unit after the edge.
  task automatic step();
    bit m_valid, m_ready, acc, con;
    m_valid = (q.size() > 0);
    m_ready = (q.size() < 2);
    acc = inValid && m_ready && !flush;
    con = m_valid && outReady;
    if (clearCount) m_cnt = 0;
    else if (!m_valid && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    if (flush) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(execute_bundle_t'(inBundle));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic compare_all(input string tag);
    logic [4:0] h0, h1;
    h0 = (q.size() > 0 && q[0].rdWriteEnable) ? q[0].rdAddr : 5'd0;
    h1 = (q.size() > 1 && q[1].rdWriteEnable) ? q[1].rdAddr : 5'd0;
    chk({tag, ".outValid"}, 128'(outValid), 128'(q.size() > 0));
    chk({tag, ".inReady"}, 128'(inReady), 128'(q.size() < 2));
    chk({tag, ".haz0"}, 128'(hazardRdAddr0), 128'(h0));
    chk({tag, ".haz1"}, 128'(hazardRdAddr1), 128'(h1));
    chk({tag, ".hazLoad"}, 128'(hazardLoad), 128'(q.size() > 0 && q[0].memoryReadEnable));
    chk({tag, ".bubble"}, 128'(bubbleCount), 128'(m_cnt));
    if (q.size() > 0) chk({tag, ".outBundle"}, 128'(outBundle), 128'(q[0]));
  endtask

  task automatic drive(input bit v, input execute_bundle_t b);
    inValid  = v;
    inBundle = b;
  endtask

  initial begin
    execute_bundle_t b;
    // Reset
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    chk("reset.outValid", 128'(outValid), 128'(0));
    chk("reset.inReady", 128'(inReady), 128'(1));
    chk("reset.outBundle", 128'(outBundle), 128'(0));
    chk("reset.bubble", 128'(bubbleCount), 128'(0));
    chk("reset.haz", 128'({hazardRdAddr0, hazardRdAddr1, hazardLoad}), 128'(0));

    // Three back-to-back bundles with outReady=1
    outReady = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, make_bundle(5'(i), 1'b1, 1'b0));
      step();
      compare_all("b2b");
      chk("b2b.rd", 128'(outBundle[RD_ADDR_LSB +: 5]), 128'(i));
      if (i == 1) chk("b2b.bubble1", 128'(bubbleCount), 128'(1));
    end
    drive(1'b0, '0);
    step();
    compare_all("b2b.drain");

    // Fill skid with outReady low
    outReady = 1'b0;
    drive(1'b1, make_bundle(5'd5, 1'b1, 1'b0));
    step();
    compare_all("fill5");
    drive(1'b1, make_bundle(5'd6, 1'b1, 1'b0));
    step();
    compare_all("fill6");
    chk("fill.inReady", 128'(inReady), 128'(0));
    chk("fill.haz0", 128'(hazardRdAddr0), 128'(5));
    chk("fill.haz1", 128'(hazardRdAddr1), 128'(6));
    drive(1'b0, '0);
    outReady = 1'b1;
    step();
    compare_all("rel5");
    chk("rel.rd6", 128'(outBundle[RD_ADDR_LSB +: 5]), 128'(6));
    step();
    compare_all("rel6");

    // Flush in TWO with an incoming bundle
    outReady = 1'b0;
    drive(1'b1, make_bundle(5'd8, 1'b1, 1'b0));
    step();
    drive(1'b1, make_bundle(5'd9, 1'b1, 1'b0));
    step();
    compare_all("pre_flush");
    drive(1'b1, make_bundle(5'd10, 1'b1, 1'b0));
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    compare_all("flush");
    chk("flush.outValid", 128'(outValid), 128'(0));
    chk("flush.haz", 128'({hazardRdAddr0, hazardRdAddr1}), 128'(0));
    outReady = 1'b1;
    repeat (2) begin
      step();
      compare_all("post_flush");
    end

    // Load hazard without register write
    outReady = 1'b0;
    drive(1'b1, make_bundle(5'd7, 1'b0, 1'b1));
    step();
    drive(1'b0, '0);
    compare_all("load");
    chk("load.hazLoad", 128'(hazardLoad), 128'(1));
    chk("load.haz0", 128'(hazardRdAddr0), 128'(0));
    outReady = 1'b1;
    step();
    compare_all("load.drain");

    // Saturation and clear
    clearCount = 1'b1;
    step();
    clearCount = 1'b0;
    repeat (20) step();
    compare_all("sat");
    chk("sat.bubble15", 128'(bubbleCount), 128'(15));
    clearCount = 1'b1;
    step();
    clearCount = 1'b0;
    chk("clear.bubble0", 128'(bubbleCount), 128'(0));
    compare_all("clear");

    // Asynchronous reset while in TWO
    outReady = 1'b0;
    drive(1'b1, make_bundle(5'd11, 1'b1, 1'b0));
    step();
    drive(1'b1, make_bundle(5'd12, 1'b1, 1'b1));
    step();
    drive(1'b0, '0);
    compare_all("pre_areset");
    #2 reset = 1'b0;
    #1;
    chk("areset.outValid", 128'(outValid), 128'(0));
    chk("areset.inReady", 128'(inReady), 128'(1));
    chk("areset.outBundle", 128'(outBundle), 128'(0));
    chk("areset.haz", 128'({hazardRdAddr0, hazardRdAddr1, hazardLoad}), 128'(0));
    chk("areset.bubble", 128'(bubbleCount), 128'(0));
    q.delete();
    m_cnt = 0;
    @(posedge clock);
    #1 reset = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      b = make_bundle(5'($urandom), 1'($urandom), 1'($urandom));
      drive(1'($urandom_range(0, 3) != 0), b);
      outReady   = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 15) == 0);
      clearCount = ($urandom_range(0, 15) == 0);
      step();
      compare_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
